// File: rtl/datapath_pkg.sv
// Shared widths and bus-driver priority indices for the bus datapath slice.
package datapath_pkg;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned OPC_W      = 4;

  // Lower index wins the bus.
  localparam int unsigned DRV_RO    = 0;
  localparam int unsigned DRV_IO    = 1;
  localparam int unsigned DRV_AO    = 2;
  localparam int unsigned DRV_EO    = 3;
  localparam int unsigned DRV_BO    = 4;
  localparam int unsigned DRV_CO    = 5;
  localparam int unsigned N_DRV     = 6;
  localparam int unsigned DRV_CNT_W = $clog2(N_DRV + 1);
endpackage

// File: rtl/datapath_alu.sv
// Combinational adder/subtractor: sum, carry-out (1 = no borrow on subtract), zero.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_su,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_cy,
  output logic              o_zr
);
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_full;

  always_comb begin
    w_b_op = i_su ? ~i_b : i_b;
    w_full = {1'b0, i_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, i_su};
    o_sum  = w_full[DATA_W-1:0];
    o_cy   = w_full[DATA_W];
    o_zr   = (w_full[DATA_W-1:0] == '0);
  end
endmodule

// File: rtl/bus_datapath.sv
// Shared-bus datapath executing sequencer control words: A, B, IR, MAR, RAM, PC, OUT, ALU.
// Optional flags register enabled by defining BUS_DATAPATH_FLAGS_EN.
module bus_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HLT,
  input  logic              MI,
  input  logic              RI,
  input  logic              RO,
  input  logic              II,
  input  logic              IO,
  input  logic              AI,
  input  logic              AO,
  input  logic              BI,
  input  logic              BO,
  input  logic              EO,
  input  logic              SU,
  input  logic              OI,
  input  logic              CE,
  input  logic              CO,
  input  logic              J,
  input  logic              FI,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [OPC_W-1:0]  opcode,
  output logic              carry,
  output logic              zero,
  output logic [DATA_W-1:0] out_value,
  output logic              halted,
  output logic [DATA_W-1:0] bus,
  output logic              bus_conflict
);
  logic [DATA_W-1:0] r_a, r_b, r_ir, r_out;
  logic [ADDR_W-1:0] r_mar, r_pc;
  logic              r_halted;
  logic [DATA_W-1:0] r_ram [2**ADDR_W];

  logic [DATA_W-1:0]    w_bus, w_sum;
  logic                 w_cy, w_zr, w_run;
  logic [N_DRV-1:0]     w_drv;
  logic [DATA_W-1:0]    w_src [N_DRV];
  logic [DRV_CNT_W-1:0] w_cnt;

  datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_su (SU),
    .o_sum(w_sum),
    .o_cy (w_cy),
    .o_zr (w_zr)
  );

  // Scan from lowest to highest priority so the highest-priority active driver lands last.
  always_comb begin
    w_drv         = '0;
    w_drv[DRV_RO] = RO;
    w_drv[DRV_IO] = IO;
    w_drv[DRV_AO] = AO;
    w_drv[DRV_EO] = EO;
    w_drv[DRV_BO] = BO;
    w_drv[DRV_CO] = CO;
    w_src[DRV_RO] = r_ram[r_mar];
    w_src[DRV_IO] = {{(DATA_W-OPC_W){1'b0}}, r_ir[OPC_W-1:0]};
    w_src[DRV_AO] = r_a;
    w_src[DRV_EO] = w_sum;
    w_src[DRV_BO] = r_b;
    w_src[DRV_CO] = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
    w_bus = '0;
    w_cnt = '0;
    for (int unsigned k = 0; k < N_DRV; k++) begin
      if (w_drv[N_DRV-1-k]) w_bus = w_src[N_DRV-1-k];
      w_cnt = w_cnt + {{(DRV_CNT_W-1){1'b0}}, w_drv[k]};
    end
  end

  assign w_run = ~r_halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_ir     <= '0;
      r_out    <= '0;
      r_mar    <= '0;
      r_pc     <= '0;
      r_halted <= 1'b0;
    end else begin
      if (HLT) r_halted <= 1'b1;
      if (w_run) begin
        if (AI) r_a   <= w_bus;
        if (BI) r_b   <= w_bus;
        if (II) r_ir  <= w_bus;
        if (OI) r_out <= w_bus;
        if (MI) r_mar <= w_bus[ADDR_W-1:0];
        if (J)       r_pc <= w_bus[ADDR_W-1:0];
        else if (CE) r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  // RAM is never cleared; a write only lands when rst is high at the edge. Program load is last so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (rst) begin
      if (RI && w_run) r_ram[r_mar]     <= w_bus;
      if (prog_we)     r_ram[prog_addr] <= prog_data;
    end
  end

`ifdef BUS_DATAPATH_FLAGS_EN
  logic [1:0] r_flags;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_flags <= '0;
    else if (FI && w_run) r_flags <= {w_cy, w_zr};
  end

  assign carry = r_flags[1];
  assign zero  = r_flags[0];
`else
  logic w_unused_flags;
  assign w_unused_flags = FI ^ w_cy ^ w_zr;
  assign carry = 1'b0;
  assign zero  = 1'b0;
`endif

  assign opcode       = r_ir[DATA_W-1 -: OPC_W];
  assign out_value    = r_out;
  assign halted       = r_halted;
  assign bus          = w_bus;
  assign bus_conflict = (w_cnt > DRV_CNT_W'(1));
endmodule

// File: tb/tb_bus_datapath.sv
// Directed self-checking bench for bus_datapath; flag expectations follow BUS_DATAPATH_FLAGS_EN.
module tb_bus_datapath;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       HLT, MI, RI, RO, II, IO, AI, AO, BI, BO, EO, SU, OI, CE, CO, J, FI;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] opcode;
  logic       carry, zero, halted, bus_conflict;
  logic [7:0] out_value, bus;

  int errors = 0;
  int checks = 0;
  logic [3:0] mar_tb;

`ifdef BUS_DATAPATH_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  bus_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .II(II), .IO(IO),
    .AI(AI), .AO(AO), .BI(BI), .BO(BO), .EO(EO), .SU(SU), .OI(OI), .CE(CE), .CO(CO),
    .J(J), .FI(FI), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .carry(carry), .zero(zero), .out_value(out_value),
    .halted(halted), .bus(bus), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  task clr_ctl();
    {HLT, MI, RI, RO, II, IO, AI, AO, BI, BO, EO, SU, OI, CE, CO, J, FI} = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
  endtask

  task tick();
    @(posedge clk); #1;
    clr_ctl();
  endtask

  task ram_put(input logic [7:0] v);
    prog_we = 1'b1; prog_addr = mar_tb; prog_data = v;
    tick();
  endtask

  task test_reset();
    clr_ctl();
    mar_tb = 4'h0;
    #3;
    checks++; if (out_value !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=%h", out_value, 8'h00); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
    checks++; if ({carry, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {carry, zero}); end
    checks++; if (bus !== 8'h00 || bus_conflict !== 1'b0) begin errors++; $display("FAIL idle_bus got=%h/%b exp=00/0", bus, bus_conflict); end
    AO = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL reset_a got=%h exp=00", bus); end
    clr_ctl();
    #3 rst = 1'b1;
    tick();
  endtask

  task test_ram_load();
    CE = 1'b1; tick();
    CE = 1'b1; tick();
    prog_we = 1'b1; prog_addr = 4'h2; prog_data = 8'h05; tick();
    CO = 1'b1; MI = 1'b1; #1;
    checks++; if (bus !== 8'h02) begin errors++; $display("FAIL pc_count got=%h exp=02", bus); end
    tick(); mar_tb = 4'h2;
    RO = 1'b1; AI = 1'b1; #1;
    checks++; if (bus !== 8'h05 || bus_conflict !== 1'b0) begin errors++; $display("FAIL ram_read got=%h/%b exp=05/0", bus, bus_conflict); end
    tick();
    AO = 1'b1; OI = 1'b1; #1;
    checks++; if (bus !== 8'h05) begin errors++; $display("FAIL a_load got=%h exp=05", bus); end
    tick();
    checks++; if (out_value !== 8'h05) begin errors++; $display("FAIL out_load got=%h exp=05", out_value); end
  endtask

  task test_alu();
    ram_put(8'h07); RO = 1'b1; BI = 1'b1; tick();
    EO = 1'b1; SU = 1'b1; #1;
    checks++; if (bus !== 8'hFE) begin errors++; $display("FAIL sub_5_7 got=%h exp=FE", bus); end
    AI = 1'b1; FI = 1'b1; tick();
    checks++; if ({carry, zero} !== 2'b00) begin errors++; $display("FAIL flags_borrow got=%b exp=00", {carry, zero}); end
    ram_put(8'hFE); RO = 1'b1; BI = 1'b1; tick();
    EO = 1'b1; SU = 1'b1; FI = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL sub_zero got=%h exp=00", bus); end
    tick();
    checks++; if ({carry, zero} !== {FLAGS, FLAGS}) begin errors++; $display("FAIL flags_zero got=%b exp=%b", {carry, zero}, {FLAGS, FLAGS}); end
    EO = 1'b1; #1;
    checks++; if (bus !== 8'hFC) begin errors++; $display("FAIL add_fe_fe got=%h exp=FC", bus); end
    tick();
    checks++; if ({carry, zero} !== {FLAGS, FLAGS}) begin errors++; $display("FAIL flags_hold got=%b exp=%b", {carry, zero}, {FLAGS, FLAGS}); end
    ram_put(8'hA3); RO = 1'b1; II = 1'b1; tick();
    checks++; if (opcode !== 4'hA) begin errors++; $display("FAIL opcode got=%h exp=A", opcode); end
    IO = 1'b1; #1;
    checks++; if (bus !== 8'h03) begin errors++; $display("FAIL ir_low got=%h exp=03", bus); end
    tick();
  endtask

  task test_pc();
    ram_put(8'h0F); RO = 1'b1; J = 1'b1; tick();
    CO = 1'b1; #1;
    checks++; if (bus !== 8'h0F || bus_conflict !== 1'b0) begin errors++; $display("FAIL pc_jump got=%h/%b exp=0F/0", bus, bus_conflict); end
    clr_ctl(); CE = 1'b1; tick();
    CO = 1'b1; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL pc_wrap got=%h exp=00", bus); end
    clr_ctl();
    ram_put(8'h09); RO = 1'b1; J = 1'b1; CE = 1'b1; tick();
    CO = 1'b1; #1;
    checks++; if (bus !== 8'h09) begin errors++; $display("FAIL jump_beats_ce got=%h exp=09", bus); end
    clr_ctl();
  endtask

  task test_conflict();
    ram_put(8'h55); RO = 1'b1; AI = 1'b1; tick();
    ram_put(8'hAA); RO = 1'b1; AO = 1'b1; #1;
    checks++; if (bus !== 8'hAA || bus_conflict !== 1'b1) begin errors++; $display("FAIL ro_vs_ao got=%h/%b exp=AA/1", bus, bus_conflict); end
    clr_ctl(); AO = 1'b1; BO = 1'b1; #1;
    checks++; if (bus !== 8'h55 || bus_conflict !== 1'b1) begin errors++; $display("FAIL ao_vs_bo got=%h/%b exp=55/1", bus, bus_conflict); end
    clr_ctl(); AO = 1'b1; RI = 1'b1;
    prog_we = 1'b1; prog_addr = mar_tb; prog_data = 8'h33; tick();
    RO = 1'b1; #1;
    checks++; if (bus !== 8'h33) begin errors++; $display("FAIL prog_beats_ri got=%h exp=33", bus); end
    clr_ctl();
  endtask

  task test_halt();
    HLT = 1'b1; tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", halted); end
    ram_put(8'h11); RO = 1'b1; AI = 1'b1; CE = 1'b1; OI = 1'b1; tick();
    AO = 1'b1; #1;
    checks++; if (bus !== 8'h55) begin errors++; $display("FAIL halt_a_hold got=%h exp=55", bus); end
    clr_ctl(); CO = 1'b1; #1;
    checks++; if (bus !== 8'h09) begin errors++; $display("FAIL halt_pc_hold got=%h exp=09", bus); end
    checks++; if (out_value !== 8'h05) begin errors++; $display("FAIL halt_out_hold got=%h exp=05", out_value); end
    clr_ctl();
    ram_put(8'h22); AO = 1'b1; RI = 1'b1; tick();
    RO = 1'b1; #1;
    checks++; if (bus !== 8'h22) begin errors++; $display("FAIL halt_prog_ri got=%h exp=22", bus); end
    clr_ctl();
    #2 rst = 1'b0; #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got=%b exp=0", halted); end
    #2 rst = 1'b1; mar_tb = 4'h0;
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_after_rst got=%b exp=0", halted); end
  endtask

  task test_async_reset();
    ram_put(8'h3C); RO = 1'b1; AI = 1'b1; tick();
    AO = 1'b1; OI = 1'b1; tick();
    ram_put(8'h07); RO = 1'b1; J = 1'b1; tick();
    CO = 1'b1; #1;
    checks++; if (bus !== 8'h07 || out_value !== 8'h3C) begin errors++; $display("FAIL pre_reset got=%h/%h exp=07/3C", bus, out_value); end
    #1 rst = 1'b0; #1;
    checks++; if (bus !== 8'h00) begin errors++; $display("FAIL async_pc got=%h exp=00", bus); end
    clr_ctl(); AO = 1'b1; #1;
    checks++; if (bus !== 8'h00 || out_value !== 8'h00) begin errors++; $display("FAIL async_a_out got=%h/%h exp=00/00", bus, out_value); end
    clr_ctl();
    #1 rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ram_load();
    test_alu();
    test_pc();
    test_conflict();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
